// File: rtl/alu_driver.sv
// Command sequencer for a combinational 4-bit ALU. Commands are queued in a small FIFO and
// issued one at a time. Each result is returned over a valid/ready port with a div/mod-by-zero flag.
module alu_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iCMD_VALID,
  output logic             oCMD_READY,
  input  logic [3:0]       iCMD_INST,
  input  logic [3:0]       iCMD_A,
  input  logic [3:0]       iCMD_B,
  output logic [3:0]       oALU_A,
  output logic [3:0]       oALU_B,
  output logic [3:0]       oALU_INST,
  input  logic [7:0]       iALU_RESULT,
  output logic             oRSP_VALID,
  input  logic             iRSP_READY,
  output logic [7:0]       oRSP_RESULT,
  output logic             oRSP_ERR,
  output logic [CNT_W-1:0] oCNT
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0] inst;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef struct packed {
    logic [7:0] result;
    logic       err;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // ---------------- command FIFO ----------------
  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  cmd_t          cmd_in, head;
  state_t        state_q;

  assign cmd_in     = '{inst: iCMD_INST, a: iCMD_A, b: iCMD_B};
  assign head       = fifo_q[rd_ptr_q];
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign oCMD_READY = ~full;
  assign push       = iCMD_VALID & ~full;
  assign pop        = (state_q == IDLE) & ~empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge iCLK) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_in;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------- issue / capture FSM ----------------
  cmd_t             alu_q;
  rsp_t             rsp_q;
  logic             rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_zero;

  assign div_zero = ((alu_q.inst == 4'h3) || (alu_q.inst == 4'h4)) && (alu_q.b == 4'h0);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q     <= IDLE;
      alu_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            alu_q   <= head;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // The ALU result for a zero divisor is undefined, so it is replaced outright.
          if (div_zero) rsp_q <= '{result: 8'h00, err: 1'b1};
          else          rsp_q <= '{result: iALU_RESULT, err: 1'b0};
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_valid_q && iRSP_READY) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oALU_A      = alu_q.a;
  assign oALU_B      = alu_q.b;
  assign oALU_INST   = alu_q.inst;
  assign oRSP_VALID  = rsp_valid_q;
  assign oRSP_RESULT = rsp_q.result;
  assign oRSP_ERR    = rsp_q.err;
  assign oCNT        = cnt_q;

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: a behavioural ALU sits on the ALU pins, a queue-based
// scoreboard follows every accepted command, and table vectors cover the fixed cases.
module tb_alu_driver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                         OP_MOD = 4'h4, OP_NOT = 4'h9, OP_RSH = 4'hE, OP_LSH = 4'hF;

  logic             iCLK, iRSTn;
  logic             iCMD_VALID, oCMD_READY;
  logic [3:0]       iCMD_INST, iCMD_A, iCMD_B;
  logic [3:0]       oALU_A, oALU_B, oALU_INST;
  logic [7:0]       iALU_RESULT;
  logic             oRSP_VALID, iRSP_READY;
  logic [7:0]       oRSP_RESULT;
  logic             oRSP_ERR;
  logic [CNT_W-1:0] oCNT;

  alu_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn),
    .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY),
    .iCMD_INST(iCMD_INST), .iCMD_A(iCMD_A), .iCMD_B(iCMD_B),
    .oALU_A(oALU_A), .oALU_B(oALU_B), .oALU_INST(oALU_INST),
    .iALU_RESULT(iALU_RESULT),
    .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY),
    .oRSP_RESULT(oRSP_RESULT), .oRSP_ERR(oRSP_ERR), .oCNT(oCNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Stand-in for the team ALU; a zero divisor yields junk that the driver must suppress.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] xa, xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (op)
      4'h0: return xa + xb;
      4'h1: return xa - xb;
      4'h2: return xa * xb;
      4'h3: return (b == 0) ? 8'hEE : xa / xb;
      4'h4: return (b == 0) ? 8'hEE : xa % xb;
      4'h5: return xa & xb;
      4'h6: return xa | xb;
      4'h7: return xa ^ xb;
      4'h8: return {4'h0, ~(a & b)};
      4'h9: return ~xa;
      4'hA: return {a, b};
      4'hB: return xa + 8'd1;
      4'hC: return xa - 8'd1;
      4'hD: return xb;
      4'hE: return xa >> b;
      default: return xa << b;
    endcase
  endfunction

  assign iALU_RESULT = alu_f(oALU_INST, oALU_A, oALU_B);

  // Expected {err, result} for one command.
  function automatic logic [8:0] ref_rsp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if ((op == OP_DIV || op == OP_MOD) && b == 0) return {1'b1, 8'h00};
    return {1'b0, alu_f(op, a, b)};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0]       exp_q[$];
  logic [8:0]       rsp_log[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             stall = 1'b0;
  logic [8:0]       held;

  always @(negedge iCLK) begin
    if (!iRSTn) begin
      exp_q.delete();
      exp_cnt = '0;
      stall   = 1'b0;
    end else begin
      if (stall) chk("rsp_hold", {oRSP_VALID, oRSP_ERR, oRSP_RESULT}, {1'b1, held});
      if (exp_q.size() >= DEPTH + 1) chk("full_ready", oCMD_READY, 0);
      if (oRSP_VALID && iRSP_READY) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp", {oRSP_ERR, oRSP_RESULT}, exp_q.pop_front());
          chk("cnt", oCNT, exp_cnt);
        end
        exp_cnt = exp_cnt + 1'b1;
        rsp_log.push_back({oRSP_ERR, oRSP_RESULT});
      end
      stall = oRSP_VALID && !iRSP_READY;
      held  = {oRSP_ERR, oRSP_RESULT};
      if (iCMD_VALID && oCMD_READY) exp_q.push_back(ref_rsp(iCMD_INST, iCMD_A, iCMD_B));
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    iCMD_VALID = 1'b1; iCMD_INST = op; iCMD_A = a; iCMD_B = b;
    @(negedge iCLK);
    while (!oCMD_READY && n < 200) begin @(negedge iCLK); n++; end
    if (!oCMD_READY) chk("send_timeout", 0, 1);
    @(posedge iCLK); #1;
    iCMD_VALID = 1'b0;
  endtask

  task automatic wait_log(input int want);
    int n = 0;
    while (rsp_log.size() < want && n < 300) begin @(posedge iCLK); #1; n++; end
    if (rsp_log.size() < want) chk("rsp_timeout", rsp_log.size(), want);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge iCLK); #1; n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge iCLK); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_alu"}, {oALU_INST, oALU_A, oALU_B}, 0);
    chk({nm, "_rsp"}, {oRSP_VALID, oRSP_ERR, oRSP_RESULT}, 0);
    chk({nm, "_cnt"}, oCNT, 0);
    chk({nm, "_ready"}, oCMD_READY, 1);
  endtask

  typedef struct {
    logic [3:0] op, a, b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{OP_ADD, 4'h3, 4'h5, 8'h08, 1'b0};
    tbl[1]  = '{OP_DIV, 4'h9, 4'h0, 8'h00, 1'b1};
    tbl[2]  = '{OP_MOD, 4'h9, 4'h4, 8'h01, 1'b0};
    tbl[3]  = '{OP_MUL, 4'h2, 4'h3, 8'h06, 1'b0};
    tbl[4]  = '{OP_SUB, 4'h7, 4'h2, 8'h05, 1'b0};
    tbl[5]  = '{OP_LSH, 4'h1, 4'h3, 8'h08, 1'b0};
    tbl[6]  = '{OP_NOT, 4'h5, 4'h0, 8'hFA, 1'b0};
    tbl[7]  = '{OP_RSH, 4'hF, 4'h2, 8'h03, 1'b0};
    tbl[8]  = '{OP_ADD, 4'h1, 4'h1, 8'h02, 1'b0};
    tbl[9]  = '{OP_MOD, 4'h7, 4'h0, 8'h00, 1'b1};
    tbl[10] = '{OP_DIV, 4'hF, 4'h3, 8'h05, 1'b0};
    tbl[11] = '{OP_ADD, 4'hF, 4'hF, 8'h1E, 1'b0};

    iRSTn = 1'b1; iCMD_VALID = 1'b0; iCMD_INST = '0; iCMD_A = '0; iCMD_B = '0; iRSP_READY = 1'b1;
    #1 iRSTn = 1'b0;
    #1 chk_reset("rst_async");
    repeat (2) @(posedge iCLK);
    #1 chk_reset("rst_hold");
    iRSTn = 1'b1;

    // ADD latency: ALU pins one edge after accept, response two edges after, count after handshake.
    send(OP_ADD, 4'h3, 4'h5);
    chk("lat_rsp_early", oRSP_VALID, 0);
    @(posedge iCLK); #1;
    chk("lat_alu", {oALU_INST, oALU_A, oALU_B}, {OP_ADD, 4'h3, 4'h5});
    chk("lat_rsp_early2", oRSP_VALID, 0);
    @(posedge iCLK); #1;
    chk("lat_rsp", {oRSP_VALID, oRSP_ERR, oRSP_RESULT}, {1'b1, 1'b0, 8'h08});
    @(posedge iCLK); #1;
    chk("lat_cnt", oCNT, 1);
    chk("lat_rsp_done", oRSP_VALID, 0);
    chk("alu_hold", {oALU_INST, oALU_A, oALU_B}, {OP_ADD, 4'h3, 4'h5});

    // Table vectors one at a time.
    for (int i = 0; i < 12; i++) begin
      rsp_log.delete();
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_log(1);
      if (rsp_log.size() >= 1) chk($sformatf("vec%0d", i), rsp_log[0], {tbl[i].err, tbl[i].res});
    end
    drain();

    // Backpressure: 5 accepted (1 in flight + DEPTH), 6th held until the consumer drains.
    rsp_log.delete();
    iRSP_READY = 1'b0;
    for (int k = 0; k < 6; k++) begin
      iCMD_VALID = 1'b1; iCMD_INST = tbl[3+k].op; iCMD_A = tbl[3+k].a; iCMD_B = tbl[3+k].b;
      @(negedge iCLK);
      chk($sformatf("bp_ready%0d", k), oCMD_READY, (k < 5) ? 1 : 0);
      if (k < 5) begin @(posedge iCLK); #1; end
    end
    repeat (3) begin @(posedge iCLK); #1; end
    chk("bp_still_full", oCMD_READY, 0);
    chk("bp_head", {oRSP_VALID, oRSP_ERR, oRSP_RESULT}, {1'b1, 1'b0, 8'h06});
    iRSP_READY = 1'b1;
    send(tbl[8].op, tbl[8].a, tbl[8].b);
    wait_log(6);
    for (int k = 0; k < 6 && k < rsp_log.size(); k++)
      chk($sformatf("bp_order%0d", k), rsp_log[k], {tbl[3+k].err, tbl[3+k].res});
    drain();

    // Random back-to-back stream with random consumer stalls.
    begin
      bit done = 0;
      fork
        begin
          for (int k = 0; k < 300; k++) begin
            send(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(3) == 0 ? 0 : $urandom_range(15)));
            if ($urandom_range(3) == 0) begin @(posedge iCLK); #1; end
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge iCLK); #1;
            iRSP_READY = ($urandom_range(3) != 0);
          end
        end
      join
    end
    iRSP_READY = 1'b1;
    drain();
    chk("rand_drained", exp_q.size(), 0);

    // Mid-stream reset with commands queued and a response pending.
    iRSP_READY = 1'b0;
    send(OP_MUL, 4'h3, 4'h3);
    send(OP_SUB, 4'h9, 4'h1);
    send(OP_ADD, 4'h2, 4'h2);
    repeat (2) begin @(posedge iCLK); #1; end
    iRSTn = 1'b0;
    #1 chk_reset("rst_mid");
    @(posedge iCLK); #1;
    chk_reset("rst_mid_hold");
    iRSTn = 1'b1;
    @(negedge iCLK);
    chk_reset("rst_release");
    @(posedge iCLK); #1;
    iRSP_READY = 1'b1;
    rsp_log.delete();
    send(OP_ADD, 4'h3, 4'h5);
    wait_log(1);
    drain();
    chk("post_rst_count", rsp_log.size(), 1);
    if (rsp_log.size() >= 1) chk("post_rst_rsp", rsp_log[0], {1'b0, 8'h08});
    chk("post_rst_cnt", oCNT, 1);

    // Counter wrap from a clean reset.
    iRSTn = 1'b0;
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    for (int k = 0; k < 255; k++) send(OP_ADD, 4'h0, 4'h0);
    drain();
    chk("cnt_255", oCNT, 255);
    send(OP_ADD, 4'h0, 4'h0);
    drain();
    chk("cnt_wrap", oCNT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
